// File: rtl/svo_tmds_pkg.sv
// svo_tmds_pkg
// Shared definitions for the TMDS transmit/receive path: the four TMDS
// control-token code words and the state type of the receive word-alignment
// machine. This package has no ports.
`timescale 1ns/1ps
package svo_tmds_pkg;

  // Control tokens as they appear on the 10-bit parallel bus; bit 0 is the
  // first bit on the wire.
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  // Receive alignment states.
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } tmds_dec_state_e;

endpackage

// File: rtl/svo_tmds_sym_dec.sv
// svo_tmds_sym_dec
// Purely combinational TMDS symbol classifier and data decoder.
// Ports:
//   din_i    [9:0] in  : 10-bit symbol, bit 0 first on the wire
//   isCtrl_o       out : symbol is one of the four control tokens
//   ctrl_o   [1:0] out : control value (00 when the symbol is data)
//   data_o   [7:0] out : decoded byte (meaningful only when isCtrl_o=0)
`timescale 1ns/1ps
module svo_tmds_sym_dec
  import svo_tmds_pkg::*;
(
  input  logic [9:0] din_i,
  output logic       isCtrl_o,
  output logic [1:0] ctrl_o,
  output logic [7:0] data_o
);

  logic [7:0] dUninv;

  always_comb begin
    isCtrl_o = 1'b1;
    ctrl_o   = 2'b00;
    case (din_i)
      TMDS_CTRL_00: ctrl_o = 2'b00;
      TMDS_CTRL_01: ctrl_o = 2'b01;
      TMDS_CTRL_10: ctrl_o = 2'b10;
      TMDS_CTRL_11: ctrl_o = 2'b11;
      default:      isCtrl_o = 1'b0;
    endcase
  end

  // Bit 9 undoes the DC-balance inversion, bit 8 selects XOR or XNOR
  // chaining of the transition-minimised byte.
  always_comb begin
    dUninv    = din_i[9] ? ~din_i[7:0] : din_i[7:0];
    data_o    = 8'h00;
    data_o[0] = dUninv[0];
    for (int i = 1; i < 8; i++) begin
      data_o[i] = din_i[8] ? (dUninv[i] ^ dUninv[i-1]) : ~(dUninv[i] ^ dUninv[i-1]);
    end
  end

endmodule

// File: rtl/svo_tmds_dec.sv
// svo_tmds_dec
// Single-lane TMDS receive decoder. Word-aligns a deserialized lane by
// pulsing bitslip until a sustained run of control tokens is seen, then
// decodes each symbol into pixel data or a control value.
// Ports:
//   clk            in  : pixel clock
//   resetn         in  : asynchronous active-low reset
//   din      [9:0] in  : deserialized symbol, din[0] first on the wire
//   bitslip        out : one-cycle pulse to the deserializer CALIB input
//   locked         out : lane word-aligned
//   de             out : current output is a data symbol
//   ctrl     [1:0] out : decoded control value, valid when de=0
//   dout     [7:0] out : decoded pixel byte, valid when de=1
//   slip_cnt [3:0] out : bitslips issued since reset, modulo 10
`timescale 1ns/1ps
module svo_tmds_dec
  import svo_tmds_pkg::*;
#(
  parameter int CTRL_RUN      = 64,
  parameter int SEARCH_WINDOW = 4096,
  parameter int SLIP_WAIT     = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] din,
  output logic       bitslip,
  output logic       locked,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] dout,
  output logic [3:0] slip_cnt
);

  localparam int RUN_W = $clog2(CTRL_RUN + 1);
  localparam int WIN_W = $clog2(SEARCH_WINDOW);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(CTRL_RUN);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [WIN_W-1:0] WAIT_LAST = WIN_W'(SLIP_WAIT - 1);

  tmds_dec_state_e state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, runInc;
  logic [WIN_W-1:0] win_q, win_d;
  logic [3:0]       slipCnt_q, slipCnt_d;
  logic             bitslip_q, locked_q, de_q;
  logic [1:0]       ctrl_q;
  logic [7:0]       dout_q;

  logic       symIsCtrl;
  logic [1:0] symCtrl;
  logic [7:0] symData;
  logic       lockNext;

  svo_tmds_sym_dec uSymDec (
    .din_i    (din),
    .isCtrl_o (symIsCtrl),
    .ctrl_o   (symCtrl),
    .data_o   (symData)
  );

  // win doubles as the settle counter while in WAIT.
  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    win_d     = win_q;
    slipCnt_d = slipCnt_q;
    runInc    = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
    case (state_q)
      ST_SEARCH: begin
        run_d = symIsCtrl ? runInc : '0;
        if (symIsCtrl && (runInc == RUN_MAX)) begin
          state_d = ST_LOCKED;
          win_d   = '0;
        end else if (win_q == WIN_LAST) begin
          state_d   = ST_SLIP;
          slipCnt_d = (slipCnt_q == 4'd9) ? 4'd0 : slipCnt_q + 4'd1;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      ST_SLIP: begin
        run_d   = '0;
        win_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        run_d = '0;
        if (win_q == WAIT_LAST) begin
          state_d = ST_SEARCH;
          win_d   = '0;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      ST_LOCKED: begin
        run_d = symIsCtrl ? runInc : '0;
        if (symIsCtrl) begin
          win_d = '0;
        end else if (win_q == WIN_LAST) begin
          state_d = ST_SEARCH;
          run_d   = '0;
          win_d   = '0;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Outputs follow the next state, so the token that completes the run is
  // decoded in the same cycle locked rises.
  assign lockNext = (state_d == ST_LOCKED);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_SEARCH;
      run_q     <= '0;
      win_q     <= '0;
      slipCnt_q <= 4'd0;
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
      de_q      <= 1'b0;
      ctrl_q    <= 2'b00;
      dout_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      win_q     <= win_d;
      slipCnt_q <= slipCnt_d;
      bitslip_q <= (state_d == ST_SLIP);
      locked_q  <= lockNext;
      de_q      <= lockNext & ~symIsCtrl;
      ctrl_q    <= (lockNext && symIsCtrl) ? symCtrl : 2'b00;
      dout_q    <= (lockNext && !symIsCtrl) ? symData : 8'h00;
    end
  end

  assign bitslip  = bitslip_q;
  assign locked   = locked_q;
  assign de       = de_q;
  assign ctrl     = ctrl_q;
  assign dout     = dout_q;
  assign slip_cnt = slipCnt_q;

endmodule

// File: tb/tb_svo_tmds_dec.sv
// tb_svo_tmds_dec
// Self-checking bench for svo_tmds_dec: aligned lock, data decode, control
// decode, exhaustive byte round trip, loss of lock, broken token runs,
// alignment of a rotated lane, and reset during the settle period.
`timescale 1ns/1ps
module tb_svo_tmds_dec;
  import svo_tmds_pkg::*;

  logic       clk;
  logic       resetn;
  logic [9:0] din;
  logic       bitslip;
  logic       locked;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] dout;
  logic [3:0] slip_cnt;

  int checkCount;
  int failCount;

  svo_tmds_dec dut (
    .clk      (clk),
    .resetn   (resetn),
    .din      (din),
    .bitslip  (bitslip),
    .locked   (locked),
    .de       (de),
    .ctrl     (ctrl),
    .dout     (dout),
    .slip_cnt (slip_cnt)
  );

  // Free-running 100 MHz pixel clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log misses.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one symbol, let it be registered, and return on the following
  // falling edge so outputs are sampled away from the active edge.
  task automatic applyStimulus(input logic [9:0] word);
    din = word;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset for a few cycles and release it on a falling edge.
  task automatic applyReset();
    resetn = 1'b0;
    din    = 10'h000;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Reference TMDS encoder: transition minimisation followed by the chosen
  // polarity of bits 7:0.
  function automatic logic [9:0] encodeWord(input logic [7:0] b, input logic inv);
    int         ones;
    logic       useXnor;
    logic [8:0] q;
    ones    = $countones(b);
    useXnor = (ones > 4) || ((ones == 4) && (b[0] == 1'b0));
    q       = 9'h000;
    q[0]    = b[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = useXnor ? ~(q[i-1] ^ b[i]) : (q[i-1] ^ b[i]);
    end
    q[8] = ~useXnor;
    return inv ? {1'b1, q[8], ~q[7:0]} : {1'b0, q[8], q[7:0]};
  endfunction

  // Lane whose word boundary is off by rot bits.
  function automatic logic [9:0] rotWord(input logic [9:0] w, input int rot);
    logic [9:0] r;
    r = 10'h000;
    for (int i = 0; i < 10; i++) begin
      r[i] = w[(i + rot) % 10];
    end
    return r;
  endfunction

  logic [7:0] byteList [4];
  logic       invList  [4];
  logic [9:0] tokList  [4];

  initial begin
    logic slipSeen;
    int   pulses;
    int   rot;
    int   expAt;
    int   n;

    checkCount = 0;
    failCount  = 0;
    resetn     = 1'b0;
    din        = 10'h000;
    byteList   = '{8'h00, 8'h55, 8'hA7, 8'hFF};
    invList    = '{1'b0, 1'b0, 1'b1, 1'b1};
    tokList    = '{TMDS_CTRL_00, TMDS_CTRL_01, TMDS_CTRL_10, TMDS_CTRL_11};

    // Reset values, checked while reset is still held.
    repeat (2) @(negedge clk);
    checkOutput("rst_bitslip", 32'(bitslip), 32'd0);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_de", 32'(de), 32'd0);
    checkOutput("rst_ctrl", 32'(ctrl), 32'd0);
    checkOutput("rst_dout", 32'(dout), 32'd0);
    checkOutput("rst_slip_cnt", 32'(slip_cnt), 32'd0);

    // Aligned lane: lock on the 64th token, then data and control decode.
    applyReset();
    slipSeen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(TMDS_CTRL_00);
      slipSeen |= bitslip;
      if (i == 62) checkOutput("lock_before_64", 32'(locked), 32'd0);
      if (i == 63) begin
        checkOutput("lock_at_64", 32'(locked), 32'd1);
        checkOutput("lock_at_64_ctrl", 32'(ctrl), 32'd0);
        checkOutput("lock_at_64_de", 32'(de), 32'd0);
      end
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(encodeWord(byteList[k], invList[k]));
      slipSeen |= bitslip;
      checkOutput($sformatf("data_de_%0h", byteList[k]), 32'(de), 32'd1);
      checkOutput($sformatf("data_dout_%0h", byteList[k]), 32'(dout), 32'(byteList[k]));
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(tokList[k]);
      slipSeen |= bitslip;
      checkOutput($sformatf("ctrl_val_%0d", k), 32'(ctrl), 32'(k));
      checkOutput($sformatf("ctrl_de_%0d", k), 32'(de), 32'd0);
    end
    checkOutput("aligned_no_bitslip", 32'(slipSeen), 32'd0);

    // Every byte in both polarities decodes back to itself.
    for (int b = 0; b < 256; b++) begin
      for (int v = 0; v < 2; v++) begin
        applyStimulus(encodeWord(8'(b), v[0]));
        checkOutput($sformatf("exh_%0h_%0d", b, v), {23'd0, de, dout}, {23'd0, 1'b1, 8'(b)});
      end
    end

    // Loss of lock after a window of data with no control token.
    applyReset();
    for (int i = 0; i < 64; i++) applyStimulus(TMDS_CTRL_00);
    checkOutput("gap_locked_start", 32'(locked), 32'd1);
    for (int g = 0; g < 4096; g++) begin
      applyStimulus(10'h100);
      if (g == 4094) begin
        checkOutput("gap_locked_4094", 32'(locked), 32'd1);
        checkOutput("gap_de_4094", 32'(de), 32'd1);
      end
      if (g == 4095) begin
        checkOutput("gap_locked_4095", 32'(locked), 32'd0);
        checkOutput("gap_de_4095", 32'(de), 32'd0);
        checkOutput("gap_dout_4095", 32'(dout), 32'd0);
        checkOutput("gap_state_search", 32'(dut.state_q), 32'(ST_SEARCH));
      end
    end

    // 63 tokens, a data word, 63 tokens: no lock; one more token locks.
    applyReset();
    for (int i = 0; i < 63; i++) applyStimulus(TMDS_CTRL_00);
    checkOutput("run63_no_lock", 32'(locked), 32'd0);
    applyStimulus(10'h100);
    for (int i = 0; i < 63; i++) applyStimulus(TMDS_CTRL_00);
    checkOutput("run63_again_no_lock", 32'(locked), 32'd0);
    applyStimulus(TMDS_CTRL_00);
    checkOutput("run_restart_lock", 32'(locked), 32'd1);

    // Lane rotated by three bits: three slips, then lock.
    applyReset();
    rot    = 3;
    pulses = 0;
    n      = 0;
    while (!locked && n < 14000) begin
      applyStimulus(rotWord(TMDS_CTRL_00, rot));
      if (bitslip) begin
        expAt = 4095 + pulses * 4113;
        checkOutput($sformatf("slip_cycle_%0d", pulses), 32'(n), 32'(expAt));
        pulses++;
        rot = (rot + 9) % 10;
      end
      n++;
    end
    checkOutput("rot_locked", 32'(locked), 32'd1);
    checkOutput("rot_slip_cnt", 32'(slip_cnt), 32'd3);
    checkOutput("rot_pulses", 32'(pulses), 32'd3);

    // Reset during WAIT clears everything at once; no slip for a full window.
    applyReset();
    n = 0;
    while (!bitslip && n < 4200) begin
      applyStimulus(10'h100);
      n++;
    end
    checkOutput("wait_slip_seen", 32'(bitslip), 32'd1);
    repeat (5) applyStimulus(10'h100);
    checkOutput("wait_in_wait", 32'(dut.state_q), 32'(ST_WAIT));
    checkOutput("wait_slip_cnt_pre", 32'(slip_cnt), 32'd1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("async_bitslip", 32'(bitslip), 32'd0);
    checkOutput("async_locked", 32'(locked), 32'd0);
    checkOutput("async_de", 32'(de), 32'd0);
    checkOutput("async_ctrl", 32'(ctrl), 32'd0);
    checkOutput("async_dout", 32'(dout), 32'd0);
    checkOutput("async_slip_cnt", 32'(slip_cnt), 32'd0);
    checkOutput("async_state", 32'(dut.state_q), 32'(ST_SEARCH));
    @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4095; i++) begin
      applyStimulus(10'h100);
      if (bitslip) pulses++;
    end
    checkOutput("post_rst_no_early_slip", 32'(pulses), 32'd0);
    applyStimulus(10'h100);
    checkOutput("post_rst_slip_4095", 32'(bitslip), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
